clint_ctrl: RTL and testbench

Core-local trap sequencer for the machine-mode CSR file. It detects synchronous traps (ecall, ebreak), `mret` and the external interrupt, then stalls the pipeline. It performs the ordered CSR writes over the CSR file's secondary write port and hands the redirect target to the pipeline control. It sits between the ex stage, the CSR file and the pipeline-control block.

---
 rtl/clint_ctrl.sv | 175 +++++++++++++++++
 tb/tb_clint_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_ctrl.sv
// ============================================================================
// Module   : clint_ctrl
// Purpose  : Core-local trap sequencer. Detects ecall / ebreak / mret and the
//            external interrupt in ex, stalls the pipeline, performs the
//            ordered machine-mode CSR writes over the CSR file's secondary
//            write port and issues a one-cycle redirect to pipeline control.
// Config   : CLINT_EBREAK_EN -- when defined, ebreak is a synchronous trap
//            with cause 3; otherwise ebreak is not decoded and acts as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        int_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] C_INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] C_INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] C_INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] C_CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] C_CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] C_CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] C_CAUSE_ECALL = 32'd11;
  localparam logic [31:0] C_CAUSE_EBRK  = 32'd3;
  localparam logic [31:0] C_CAUSE_EXT   = 32'h8000_000B;

  // State names the write/assert currently presented on the registered outputs
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MCAUSE  = 3'd3,
    S_ASSERT  = 3'd4,
    S_MRET    = 3'd5
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [31:0] waddr_q;
  logic [31:0] data_q;
  logic        int_assert_q;
  logic [31:0] int_addr_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;

  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        sync_req;
  logic        async_req;
  logic        in_idle;
  logic        trap_go;
  logic        mret_go;
  logic [31:0] epc_d;
  logic [31:0] cause_d;
  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;

  // Decode of ex-stage events and the values latched on trap entry
  always_comb begin
    is_ecall  = (inst_i == C_INST_ECALL);
`ifdef CLINT_EBREAK_EN
    is_ebreak = (inst_i == C_INST_EBREAK);
`else
    is_ebreak = 1'b0;
`endif
    is_mret   = (inst_i == C_INST_MRET);
    sync_req  = is_ecall | is_ebreak;
    async_req = int_flag_i & global_int_en_i;
    in_idle   = (state_q == S_IDLE);
    // sync beats mret beats async
    trap_go   = in_idle & (sync_req | (~is_mret & async_req));
    mret_go   = in_idle & ~sync_req & is_mret;
    // An interrupt taken while ex redirects must resume at the redirect target
    epc_d     = (~sync_req & jump_flag_i) ? jump_addr_i : inst_addr_i;
    cause_d   = sync_req ? (is_ecall ? C_CAUSE_ECALL : C_CAUSE_EBRK) : C_CAUSE_EXT;
    // Trap entry: MPIE <- MIE, MIE <- 0.  Return: MIE <- MPIE, MPIE <- 1.
    mstatus_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                    1'b0, csr_mstatus_i[2:0]};
    mstatus_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                    csr_mstatus_i[7], csr_mstatus_i[2:0]};
  end

  // Sequencer: advances one step per cycle and registers the outputs of the next step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      waddr_q      <= 32'd0;
      data_q       <= 32'd0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'd0;
      epc_q        <= 32'd0;
      cause_q      <= 32'd0;
    end else begin
      we_q         <= 1'b0;
      waddr_q      <= 32'd0;
      data_q       <= 32'd0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'd0;
      case (state_q)
        S_IDLE: begin
          if (trap_go) begin
            epc_q   <= epc_d;
            cause_q <= cause_d;
            state_q <= S_MEPC;
            we_q    <= 1'b1;
            waddr_q <= C_CSR_MEPC;
            data_q  <= epc_d;
          end else if (mret_go) begin
            state_q <= S_MRET;
            we_q    <= 1'b1;
            waddr_q <= C_CSR_MSTATUS;
            data_q  <= mstatus_mret;
          end
        end
        S_MEPC: begin
          state_q <= S_MSTATUS;
          we_q    <= 1'b1;
          waddr_q <= C_CSR_MSTATUS;
          data_q  <= mstatus_trap;
        end
        S_MSTATUS: begin
          state_q <= S_MCAUSE;
          we_q    <= 1'b1;
          waddr_q <= C_CSR_MCAUSE;
          data_q  <= cause_q;
        end
        S_MCAUSE: begin
          state_q      <= S_ASSERT;
          int_assert_q <= 1'b1;
          int_addr_q   <= csr_mtvec_i;
        end
        S_MRET: begin
          state_q      <= S_ASSERT;
          int_assert_q <= 1'b1;
          int_addr_q   <= csr_mepc_i;
        end
        S_ASSERT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall covers the trigger cycle combinationally, then every non-idle state
  assign hold_flag_o  = ~in_idle | trap_go | mret_go;
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_clint_ctrl.sv
// ============================================================================
// Module   : tb_clint_ctrl
// Purpose  : Self-checking bench for clint_ctrl: a per-cycle plan model of the
//            expected CSR write / redirect sequence plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_ctrl;

`ifdef CLINT_EBREAK_EN
  localparam bit EBREAK_ON = 1'b1;
`else
  localparam bit EBREAK_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        int_flag;
  logic        mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        hold;
  logic        iassert;
  logic [31:0] iaddr;

  int checks = 0;
  int errors = 0;

  clint_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inst_i          (inst),
    .inst_addr_i     (inst_addr),
    .jump_flag_i     (jump_flag),
    .jump_addr_i     (jump_addr),
    .int_flag_i      (int_flag),
    .global_int_en_i (mie),
    .csr_mtvec_i     (mtvec),
    .csr_mepc_i      (mepc),
    .csr_mstatus_i   (mstatus),
    .we_o            (we),
    .waddr_o         (waddr),
    .data_o          (wdata),
    .hold_flag_o     (hold),
    .int_assert_o    (iassert),
    .int_addr_o      (iaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        as;
    logic [31:0] ia;
  } exp_t;

  exp_t plan[$];
  exp_t e;
  int   kind;
  logic h_exp;
  logic [31:0] m_epc, m_cause;

  // 0 none, 1 ecall, 2 ebreak, 3 mret, 4 external interrupt
  function automatic int trig_kind();
    if (inst == 32'h0000_0073) return 1;
    if (EBREAK_ON && inst == 32'h0010_0073) return 2;
    if (inst == 32'h3020_0073) return 3;
    if (int_flag && mie) return 4;
    return 0;
  endfunction

  always @(negedge clk) begin
    e = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0};
    kind = trig_kind();
    if (!rst) begin
      plan.delete();
      h_exp = (kind != 0);
    end else if (plan.size() > 0) begin
      e = plan.pop_front();
      h_exp = 1'b1;
    end else begin
      h_exp = (kind != 0);
      if (kind == 3) begin
        plan.push_back('{1'b1, 32'h300,
                         (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0),
                         1'b0, 32'd0});
        plan.push_back('{1'b0, 32'd0, 32'd0, 1'b1, mepc});
      end else if (kind != 0) begin
        m_epc   = (kind == 4 && jump_flag) ? jump_addr : inst_addr;
        m_cause = (kind == 1) ? 32'd11 : (kind == 2) ? 32'd3 : 32'h8000_000B;
        plan.push_back('{1'b1, 32'h341, m_epc, 1'b0, 32'd0});
        plan.push_back('{1'b1, 32'h300,
                         (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0),
                         1'b0, 32'd0});
        plan.push_back('{1'b1, 32'h342, m_cause, 1'b0, 32'd0});
        plan.push_back('{1'b0, 32'd0, 32'd0, 1'b1, mtvec});
      end
    end
    chk("model_we",    {31'd0, we},      {31'd0, e.we});
    chk("model_waddr", waddr,            e.wa);
    chk("model_data",  wdata,            e.wd);
    chk("model_hold",  {31'd0, hold},    {31'd0, h_exp});
    chk("model_asrt",  {31'd0, iassert}, {31'd0, e.as});
    chk("model_iaddr", iaddr,            e.ia);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    inst      = 32'h0000_0013;
    inst_addr = 32'd0;
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    int_flag  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    mie = 1'b0; mtvec = 32'h200; mepc = 32'h0; mstatus = 32'h8;
    repeat (3) step();
    @(negedge clk);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", waddr, 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_assert", {31'd0, iassert}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    step(); rst = 1'b1;
    repeat (2) step();

    // ecall
    inst = 32'h73; inst_addr = 32'h100;
    @(negedge clk); chk("ecall_hold_T", {31'd0, hold}, 32'd1);
    step(); idle_in();
    @(negedge clk); chk("ecall_mepc_a", waddr, 32'h341); chk("ecall_mepc_d", wdata, 32'h100);
    step();
    @(negedge clk); chk("ecall_mst_a", waddr, 32'h300); chk("ecall_mst_d", wdata, 32'h80);
    step();
    @(negedge clk); chk("ecall_mcause_a", waddr, 32'h342); chk("ecall_mcause_d", wdata, 32'd11);
    step();
    @(negedge clk); chk("ecall_assert", {31'd0, iassert}, 32'd1); chk("ecall_target", iaddr, 32'h200);
    chk("ecall_hold_T4", {31'd0, hold}, 32'd1);
    step();
    @(negedge clk); chk("ecall_hold_T5", {31'd0, hold}, 32'd0);
    step();

    // external interrupt during an ex redirect
    mie = 1'b1;
    int_flag = 1'b1; jump_flag = 1'b1; jump_addr = 32'h340; inst_addr = 32'h500;
    step(); idle_in(); mie = 1'b0;
    @(negedge clk); chk("async_mepc", wdata, 32'h340);
    step(); step();
    @(negedge clk); chk("async_mcause", wdata, 32'h8000_000B);
    repeat (3) step();

    // mret
    mstatus = 32'h80; mepc = 32'h104;
    inst = 32'h3020_0073;
    step(); idle_in();
    @(negedge clk); chk("mret_mst_a", waddr, 32'h300); chk("mret_mst_d", wdata, 32'h88);
    step();
    @(negedge clk); chk("mret_assert", {31'd0, iassert}, 32'd1); chk("mret_target", iaddr, 32'h104);
    repeat (2) step();

    // ecall together with an enabled interrupt; interrupt stays high afterwards
    mstatus = 32'h8; mie = 1'b1;
    inst = 32'h73; inst_addr = 32'h180; int_flag = 1'b1;
    step(); inst = 32'h13;
    step(); mie = 1'b0;
    step();
    @(negedge clk); chk("prio_cause", wdata, 32'd11);
    step(); step();
    @(negedge clk); chk("prio_no_retake", {31'd0, hold}, 32'd0);
    repeat (2) step();
    idle_in();
    step();

    // reset in the middle of a trap
    inst = 32'h73; inst_addr = 32'h100;
    step(); idle_in();
    step(); rst = 1'b0;
    @(negedge clk); chk("abort_we", {31'd0, we}, 32'd0); chk("abort_hold", {31'd0, hold}, 32'd0);
    step();
    @(negedge clk); chk("abort_assert", {31'd0, iassert}, 32'd0);
    step(); rst = 1'b1;
    step();
    inst = 32'h73; inst_addr = 32'h100;
    step(); idle_in();
    step(); step();
    @(negedge clk); chk("rerun_mcause", waddr, 32'h342);
    step();
    @(negedge clk); chk("rerun_target", iaddr, 32'h200);
    repeat (2) step();

    // ebreak
    inst = 32'h0010_0073; inst_addr = 32'h220;
    @(negedge clk); chk("ebreak_hold", {31'd0, hold}, {31'd0, EBREAK_ON});
    step(); idle_in();
    @(negedge clk); chk("ebreak_we", {31'd0, we}, {31'd0, EBREAK_ON});
    step(); step();
    @(negedge clk); chk("ebreak_cause", wdata, EBREAK_ON ? 32'd3 : 32'd0);
    repeat (3) step();

    // mret beats a simultaneous interrupt
    mstatus = 32'h88; mie = 1'b1; int_flag = 1'b1; inst = 32'h3020_0073;
    step(); idle_in(); mie = 1'b0;
    @(negedge clk); chk("mret_prio_a", waddr, 32'h300);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
